// File: rtl/svfloat_round_packer.sv
// svfloat_round_packer: rounds and packs an unnormalised (sign, exponent, mantissa)
// triple into an IEEE-754 style binary format (exp_bits / man_bits) in two stages.
//   S1: leading-one find, normalise, subnormal denormalise, guard/sticky capture.
//   S2: rounding (RNE/RTZ/RDN/RUP/RMM), renormalise, overflow/special handling, flags.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : input handshake (in_ready combinational from out_ready)
//   is_nan/is_inf/is_zero : per-beat overrides, priority nan > inf > zero
//   d_sign, d_exp, d_man  : value = (-1)^d_sign * d_man / 2^frac * 2^d_exp
//   rm                    : rounding mode, 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM, 5-7 RNE
//   out_valid / out_ready : output handshake
//   res                   : {sign, exponent, mantissa}
//   flags                 : {NV, OF, UF, NX}
module svfloat_round_packer #(
    parameter int unsigned exp_bits = 8,
    parameter int unsigned man_bits = 23,
    parameter int unsigned ewidth   = 10,
    parameter int unsigned width    = 48,
    parameter int unsigned frac     = 46
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           is_inf,
    input  logic                           is_nan,
    input  logic                           is_zero,
    input  logic                           d_sign,
    input  logic signed [ewidth-1:0]       d_exp,
    input  logic        [width-1:0]        d_man,
    input  logic        [2:0]              rm,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic        [exp_bits+man_bits:0] res,
    output logic        [3:0]              flags
);

    localparam int unsigned MW    = man_bits + 1;
    localparam int unsigned SUMW  = MW + 1;
    localparam int unsigned XW    = ewidth + 2;
    localparam int unsigned RW    = 1 + exp_bits + man_bits;
    localparam int unsigned SW    = $clog2(width);
    localparam int unsigned BIAS  = (1 << (exp_bits - 1)) - 1;
    localparam int unsigned EMAXF = (1 << exp_bits) - 1;

    // Stage 1 registers
    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_sign_q,  s1_sign_d;
    logic [2:0]           s1_rm_q,    s1_rm_d;
    logic                 s1_nan_q,   s1_nan_d;
    logic                 s1_snan_q,  s1_snan_d;
    logic                 s1_inf_q,   s1_inf_d;
    logic                 s1_zero_q,  s1_zero_d;
    logic [MW-1:0]        s1_man_q,   s1_man_d;
    logic                 s1_grd_q,   s1_grd_d;
    logic                 s1_stk_q,   s1_stk_d;
    logic signed [XW-1:0] s1_bexp_q,  s1_bexp_d;
    logic                 s1_tiny_q,  s1_tiny_d;

    // Stage 2 (output) registers
    logic                 out_valid_q, out_valid_d;
    logic [RW-1:0]        res_q,       res_d;
    logic [3:0]           flags_q,     flags_d;

    logic                 s2_ready;

    // S1 combinational datapath
    logic [SW-1:0]        msb_c;
    logic [width-1:0]     norm_c;
    logic [width-1:0]     dn_c;
    logic [width-1:0]     lost_mask_c;
    logic signed [XW-1:0] bexp_c;
    logic                 tiny_c;
    logic [XW-1:0]        sh_c;

    // S2 combinational datapath
    logic                 nx_c;
    logic                 rnd_up_c;
    logic [SUMW-1:0]      sum_c;
    logic                 carry_c;
    logic [MW-1:0]        man_r_c;
    logic signed [XW-1:0] eb_c;
    logic                 ovf_c;
    logic                 to_max_c;
    logic [RW-1:0]        res_c;
    logic [3:0]           flags_c;

    // Stage 2 takes a new beat when empty or its result is being consumed.
    assign s2_ready = ~out_valid_q | out_ready;
    assign in_ready = ~s1_valid_q | s2_ready;

    // Leading-one position of the input mantissa.
    always_comb begin : s1_msb
        msb_c = '0;
        for (int i = 0; i < int'(width); i++) begin
            if (d_man[i]) msb_c = SW'(i);
        end
    end

    // Normalise; tiny values are shifted so their exponent sits at the minimum normal (biased 1).
    always_comb begin : s1_norm
        norm_c      = d_man << (SW'(width - 1) - msb_c);
        bexp_c      = $signed({{2{d_exp[ewidth-1]}}, d_exp}) - $signed(XW'(frac))
                    + $signed(XW'(msb_c)) + $signed(XW'(BIAS));
        tiny_c      = bexp_c < $signed(XW'(1));
        sh_c        = tiny_c ? XW'($signed(XW'(1)) - bexp_c) : '0;
        lost_mask_c = ~({width{1'b1}} << sh_c);
        dn_c        = norm_c >> sh_c;
    end

    // Stage 1 capture.
    always_comb begin : s1_next
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_rm_d    = s1_rm_q;
        s1_nan_d   = s1_nan_q;
        s1_snan_d  = s1_snan_q;
        s1_inf_d   = s1_inf_q;
        s1_zero_d  = s1_zero_q;
        s1_man_d   = s1_man_q;
        s1_grd_d   = s1_grd_q;
        s1_stk_d   = s1_stk_q;
        s1_bexp_d  = s1_bexp_q;
        s1_tiny_d  = s1_tiny_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sign_d = d_sign;
                s1_rm_d   = rm;
                s1_nan_d  = is_nan;
                s1_snan_d = ~d_man[width-1];
                s1_inf_d  = is_inf;
                s1_zero_d = is_zero | (d_man == '0);
                s1_man_d  = dn_c[width-1 -: MW];
                s1_grd_d  = dn_c[width-1-MW];
                s1_stk_d  = (|dn_c[width-2-MW:0]) | (|(norm_c & lost_mask_c));
                s1_bexp_d = tiny_c ? $signed(XW'(1)) : bexp_c;
                s1_tiny_d = tiny_c;
            end
        end
    end

    // Rounding increment and renormalisation on mantissa carry-out.
    always_comb begin : s2_round
        nx_c     = s1_grd_q | s1_stk_q;
        rnd_up_c = 1'b0;
        case (s1_rm_q)
            3'd1:    rnd_up_c = 1'b0;
            3'd2:    rnd_up_c = s1_sign_q & nx_c;
            3'd3:    rnd_up_c = ~s1_sign_q & nx_c;
            3'd4:    rnd_up_c = s1_grd_q;
            default: rnd_up_c = s1_grd_q & (s1_stk_q | s1_man_q[0]);
        endcase
        sum_c    = {1'b0, s1_man_q} + SUMW'(rnd_up_c);
        carry_c  = sum_c[MW];
        man_r_c  = carry_c ? sum_c[MW:1] : sum_c[MW-1:0];
        eb_c     = s1_bexp_q + $signed(XW'(carry_c));
        ovf_c    = eb_c >= $signed(XW'(EMAXF));
        to_max_c = (s1_rm_q == 3'd1)
                 | ((s1_rm_q == 3'd2) & ~s1_sign_q)
                 | ((s1_rm_q == 3'd3) &  s1_sign_q);
    end

    // Result packing; a cleared hidden bit after rounding means a subnormal (exponent field 0).
    always_comb begin : s2_pack
        res_c   = '0;
        flags_c = '0;
        if (s1_nan_q) begin
            res_c   = {1'b0, {exp_bits{1'b1}}, 1'b1, {(man_bits-1){1'b0}}};
            flags_c = {s1_snan_q, 3'b000};
        end else if (s1_inf_q) begin
            res_c = {s1_sign_q, {exp_bits{1'b1}}, {man_bits{1'b0}}};
        end else if (s1_zero_q) begin
            res_c = {s1_sign_q, {(RW-1){1'b0}}};
        end else if (ovf_c) begin
            res_c   = to_max_c ? {s1_sign_q, exp_bits'(EMAXF - 1), {man_bits{1'b1}}}
                               : {s1_sign_q, {exp_bits{1'b1}}, {man_bits{1'b0}}};
            flags_c = 4'b0101;
        end else begin
            res_c   = {s1_sign_q,
                       man_r_c[MW-1] ? eb_c[exp_bits-1:0] : {exp_bits{1'b0}},
                       man_r_c[man_bits-1:0]};
            flags_c = {2'b00, s1_tiny_q & nx_c, nx_c};
        end
    end

    // Output stage next state; held while stalled.
    always_comb begin : s2_next
        out_valid_d = out_valid_q;
        res_d       = res_q;
        flags_d     = flags_q;
        if (s2_ready) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_d   = res_c;
                flags_d = flags_c;
            end
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin : regs
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_rm_q     <= '0;
            s1_nan_q    <= 1'b0;
            s1_snan_q   <= 1'b0;
            s1_inf_q    <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_man_q    <= '0;
            s1_grd_q    <= 1'b0;
            s1_stk_q    <= 1'b0;
            s1_bexp_q   <= '0;
            s1_tiny_q   <= 1'b0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            flags_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_rm_q     <= s1_rm_d;
            s1_nan_q    <= s1_nan_d;
            s1_snan_q   <= s1_snan_d;
            s1_inf_q    <= s1_inf_d;
            s1_zero_q   <= s1_zero_d;
            s1_man_q    <= s1_man_d;
            s1_grd_q    <= s1_grd_d;
            s1_stk_q    <= s1_stk_d;
            s1_bexp_q   <= s1_bexp_d;
            s1_tiny_q   <= s1_tiny_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign flags     = flags_q;

endmodule
